// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master Wishbone classic arbiter, grant held for the whole cyc of the winner.
// Optional feature: define WB_ARB_ROUND_ROBIN_EN for round-robin tie breaking (default: master 1 wins ties).
module wb_arbiter2 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic [DATA_W-1:0] m0_dat_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_dat_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_dat_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_adr_o,
    output logic [DATA_W-1:0] s_dat_o,
    input  logic              s_ack_i,
    input  logic [DATA_W-1:0] s_dat_i,
    output logic [1:0]        gnt_o
);
    typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} state_t;
    state_t r_state;
    logic   r_last;
    logic   w_req0, w_req1, w_tie1, w_pick1, w_g0, w_g1;
    state_t w_arb;
    assign w_req0 = m0_cyc_i & m0_stb_i;
    assign w_req1 = m1_cyc_i & m1_stb_i;
`ifdef WB_ARB_ROUND_ROBIN_EN
    assign w_tie1 = ~r_last;
`else
    // last is still tracked in fixed-priority builds but never changes the outcome
    assign w_tie1 = 1'b1 | r_last;
`endif
    assign w_pick1 = w_req1 & (~w_req0 | w_tie1);
    assign w_arb   = w_pick1 ? GNT1 : w_req0 ? GNT0 : IDLE;
    assign w_g0    = r_state == GNT0;
    assign w_g1    = r_state == GNT1;
    assign gnt_o   = r_state;
    // grant FSM: arbitrate from IDLE, hold while the owner keeps cyc, hand over directly on release
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else if (en) begin
            case (r_state)
                GNT0: if (!m0_cyc_i) begin
                    r_state <= w_arb;
                    r_last  <= 1'b0;
                end
                GNT1: if (!m1_cyc_i) begin
                    r_state <= w_arb;
                    r_last  <= 1'b1;
                end
                default: r_state <= w_arb;
            endcase
        end
    end
    // slave-side mux and response routing follow the registered grant
    always_comb begin
        s_cyc_o  = w_g0 ? m0_cyc_i : w_g1 ? m1_cyc_i : 1'b0;
        s_stb_o  = w_g0 ? m0_stb_i : w_g1 ? m1_stb_i : 1'b0;
        s_we_o   = w_g0 ? m0_we_i  : w_g1 ? m1_we_i  : 1'b0;
        s_adr_o  = w_g0 ? m0_adr_i : w_g1 ? m1_adr_i : '0;
        s_dat_o  = w_g0 ? m0_dat_i : w_g1 ? m1_dat_i : '0;
        m0_ack_o = w_g0 & s_ack_i;
        m1_ack_o = w_g1 & s_ack_i;
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
    end
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed vector bench for wb_arbiter2 with a zero-wait two-word memory.
module tb_wb_arbiter2;
    logic        clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [31:0] m0_adr = 32'h0040_0000, m1_adr = 32'h8000_0000;
    logic [31:0] m0_wdat = 32'h1111_1111, m1_wdat = 32'hCAFE_BABE;
    logic        m0_ack, m1_ack, s_cyc, s_stb, s_we, s_ack;
    logic [31:0] m0_rdat, m1_rdat, s_adr, s_wdat, s_rdat;
    logic [1:0]  gnt;
    logic [31:0] r_d80 = 32'h0;
    int          n_vec = 0, n_err = 0;

`ifdef WB_ARB_ROUND_ROBIN_EN
    localparam bit FIRST1 = 1'b0;
`else
    localparam bit FIRST1 = 1'b1;
`endif

    wb_arbiter2 dut (
        .clk(clk), .rst(rst), .en(en),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat),
        .m0_ack_o(m0_ack), .m0_dat_o(m0_rdat),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat),
        .m1_ack_o(m1_ack), .m1_dat_o(m1_rdat),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_wdat),
        .s_ack_i(s_ack), .s_dat_i(s_rdat), .gnt_o(gnt)
    );

    always #5 clk = ~clk;

    assign s_ack  = s_cyc & s_stb;
    assign s_rdat = (s_adr == 32'h8000_0000) ? r_d80 : 32'h0000_0013;
    always @(posedge clk) if (s_ack && s_we && s_adr == 32'h8000_0000) r_d80 <= s_wdat;

    typedef struct {
        bit        rst, en, c0, s0, w0, c1, s1, w1;
        bit [1:0]  g;
        bit        a0, a1, sc, cd;
        bit [31:0] d;
    } vec_t;

    function automatic vec_t mk(bit r, bit e, bit c0, bit s0, bit w0, bit c1, bit s1, bit w1,
                                bit [1:0] g, bit a0, bit a1, bit sc, bit cd, bit [31:0] d);
        vec_t v;
        v.rst = r; v.en = e; v.c0 = c0; v.s0 = s0; v.w0 = w0; v.c1 = c1; v.s1 = s1; v.w1 = w1;
        v.g = g; v.a0 = a0; v.a1 = a1; v.sc = sc; v.cd = cd; v.d = d;
        return v;
    endfunction

    task automatic apply(input string name, input vec_t v);
        logic [68:0] act, exp;
        rst = v.rst; en = v.en;
        m0_cyc = v.c0; m0_stb = v.s0; m0_we = v.w0;
        m1_cyc = v.c1; m1_stb = v.s1; m1_we = v.w1;
        @(negedge clk);
        act = {gnt, m0_ack, m1_ack, s_cyc, v.cd ? m0_rdat : 32'h0, v.cd ? m1_rdat : 32'h0};
        exp = {v.g, v.a0, v.a1, v.sc, v.cd ? v.d : 32'h0, v.cd ? v.d : 32'h0};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got gnt/ack0/ack1/scyc/dat0/dat1=%h, want %h", name, act, exp);
        end
        @(posedge clk);
        #1;
    endtask

    localparam bit [31:0] TXT = 32'h0000_0013, CB = 32'hCAFE_BABE;
    vec_t tab[21];
    bit   cur;

    initial begin
        tab[0]  = mk(1,0, 0,0,0, 0,0,0, 2'b00, 0,0,0, 0, 0);
        tab[1]  = mk(0,1, 1,1,0, 0,0,0, 2'b00, 0,0,0, 0, 0);
        tab[2]  = mk(0,1, 1,1,0, 0,0,0, 2'b01, 1,0,1, 1, TXT);
        tab[3]  = mk(0,1, 0,0,0, 0,0,0, 2'b01, 0,0,0, 0, 0);
        tab[4]  = mk(0,1, 0,0,0, 0,0,0, 2'b00, 0,0,0, 0, 0);
        tab[5]  = mk(0,1, 0,0,0, 1,1,1, 2'b00, 0,0,0, 0, 0);
        tab[6]  = mk(0,1, 1,1,0, 1,1,1, 2'b10, 0,1,1, 0, 0);
        tab[7]  = mk(0,1, 1,1,0, 1,1,0, 2'b10, 0,1,1, 1, CB);
        tab[8]  = mk(0,1, 1,1,0, 1,0,0, 2'b10, 0,0,1, 0, 0);
        tab[9]  = mk(0,1, 1,1,0, 1,1,0, 2'b10, 0,1,1, 1, CB);
        tab[10] = mk(0,1, 1,1,0, 0,0,0, 2'b10, 0,0,0, 0, 0);
        tab[11] = mk(0,1, 1,1,0, 0,0,0, 2'b01, 1,0,1, 1, TXT);
        tab[12] = mk(0,1, 0,0,0, 1,1,0, 2'b01, 0,0,0, 0, 0);
        tab[13] = mk(0,1, 0,0,0, 1,1,0, 2'b10, 0,1,1, 1, CB);
        tab[14] = mk(0,0, 0,0,0, 0,0,0, 2'b10, 0,0,0, 0, 0);
        tab[15] = mk(0,0, 1,1,0, 0,0,0, 2'b10, 0,0,0, 0, 0);
        tab[16] = mk(0,1, 1,1,0, 0,0,0, 2'b10, 0,0,0, 0, 0);
        tab[17] = mk(0,1, 1,1,0, 0,0,0, 2'b01, 1,0,1, 1, TXT);
        tab[18] = mk(1,1, 1,1,0, 0,0,0, 2'b01, 1,0,1, 1, TXT);
        tab[19] = mk(1,1, 1,1,0, 0,0,0, 2'b00, 0,0,0, 0, 0);
        tab[20] = mk(0,1, 0,0,0, 0,0,0, 2'b00, 0,0,0, 0, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 21; i++) apply($sformatf("vec%0d", i), tab[i]);
        apply("tie_idle", mk(0,1, 1,1,0, 1,1,0, 2'b00, 0,0,0, 0, 0));
        apply("tie_win", mk(0,1, 1,1,0, 1,1,0, FIRST1 ? 2'b10 : 2'b01, !FIRST1, FIRST1, 1, 1,
                             FIRST1 ? CB : TXT));
        apply("tie_release", mk(0,1, FIRST1,FIRST1,0, !FIRST1,!FIRST1,0,
                                 FIRST1 ? 2'b10 : 2'b01, 0,0,0, 0, 0));
        apply("tie_handover", mk(0,1, 1,1,0, 1,1,0, FIRST1 ? 2'b01 : 2'b10, FIRST1, !FIRST1, 1, 1,
                                  FIRST1 ? TXT : CB));
        cur = !FIRST1;
        for (int k = 0; k < 10; k++) begin
            apply($sformatf("fair_drop%0d", k), mk(0,1, cur,cur,0, !cur,!cur,0,
                                                    cur ? 2'b10 : 2'b01, 0,0,0, 0, 0));
            cur = !cur;
            apply($sformatf("fair_gnt%0d", k), mk(0,1, 1,1,0, 1,1,0, cur ? 2'b10 : 2'b01,
                                                   !cur, cur, 1, 1, cur ? CB : TXT));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
